// File: rtl/ysyx_23060208_lsu.sv
// Load/store unit: accepts one EXU request at a time and turns it into a single-beat
// AXI4 read or write on a bus that may be wider than the core word. Misaligned
// requests and non-OKAY bus responses are reported back through resp_err.
module ysyx_23060208_lsu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BUS_WIDTH  = 64,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  // EXU request
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic [DATA_WIDTH-1:0]   req_addr,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  // EXU response
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic [1:0]              resp_err,
  // AXI write address
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   awaddr,
  output logic [ID_WIDTH-1:0]     awid,
  output logic [2:0]              awsize,
  output logic [7:0]              awlen,
  output logic [1:0]              awburst,
  // AXI write data
  output logic                    wvalid,
  input  logic                    wready,
  output logic [BUS_WIDTH-1:0]    wdata,
  output logic [BUS_WIDTH/8-1:0]  wstrb,
  output logic                    wlast,
  // AXI write response
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp,
  input  logic [ID_WIDTH-1:0]     bid,
  // AXI read address
  output logic                    arvalid,
  input  logic                    arready,
  output logic [DATA_WIDTH-1:0]   araddr,
  output logic [ID_WIDTH-1:0]     arid,
  output logic [2:0]              arsize,
  output logic [7:0]              arlen,
  output logic [1:0]              arburst,
  // AXI read data
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [BUS_WIDTH-1:0]    rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic [ID_WIDTH-1:0]     rid
);
  localparam int unsigned STRB_WIDTH = BUS_WIDTH / 8;
  localparam int unsigned OFF_WIDTH  = $clog2(STRB_WIDTH);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAr   = 3'd1;
  localparam logic [2:0] StR    = 3'd2;
  localparam logic [2:0] StAwW  = 3'd3;
  localparam logic [2:0] StB    = 3'd4;
  localparam logic [2:0] StResp = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [OFF_WIDTH-1:0]  off_q, off_d;
  logic [BUS_WIDTH-1:0]  wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ID_WIDTH-1:0]   id_cnt_q, id_cnt_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            err_q, err_d;

  logic                  req_misaligned;
  logic [OFF_WIDTH-1:0]  req_size_mask;
  logic [OFF_WIDTH-1:0]  req_off;
  logic [STRB_WIDTH-1:0] req_strb_base;
  logic [BUS_WIDTH-1:0]  req_wdata_rep;

  // Request decode: alignment, byte-lane offset, strobes and store data.
  // The access-sized datum is replicated so it lands on whichever lanes the strobe selects.
  always_comb begin
    req_size_mask = '0;
    req_strb_base = '0;
    req_wdata_rep = '0;
    case (req_size)
      2'd0: begin
        req_strb_base[0] = 1'b1;
        req_wdata_rep    = {(BUS_WIDTH/8){req_wdata[7:0]}};
      end
      2'd1: begin
        req_size_mask[0]   = 1'b1;
        req_strb_base[1:0] = 2'b11;
        req_wdata_rep      = {(BUS_WIDTH/16){req_wdata[15:0]}};
      end
      default: begin
        req_size_mask[1:0] = 2'b11;
        req_strb_base[3:0] = 4'hf;
        req_wdata_rep      = {(BUS_WIDTH/32){req_wdata[31:0]}};
      end
    endcase
    req_off        = req_addr[OFF_WIDTH-1:0] & ~req_size_mask;
    req_misaligned = (req_size == 2'd3) ||
                     ((req_size == 2'd1) && req_addr[0]) ||
                     ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  end

  logic [BUS_WIDTH-1:0]  rdata_shift;
  logic                  load_sign;
  logic [DATA_WIDTH-1:0] load_ext;

  // Load data: move the addressed lanes to bit 0, truncate, then sign/zero extend
  always_comb begin
    rdata_shift = rdata >> {off_q, 3'b000};
    load_sign   = 1'b0;
    load_ext    = '0;
    case (size_q)
      2'd0: begin
        load_sign     = ~uns_q & rdata_shift[7];
        load_ext      = {DATA_WIDTH{load_sign}};
        load_ext[7:0] = rdata_shift[7:0];
      end
      2'd1: begin
        load_sign      = ~uns_q & rdata_shift[15];
        load_ext       = {DATA_WIDTH{load_sign}};
        load_ext[15:0] = rdata_shift[15:0];
      end
      default: begin
        load_sign      = ~uns_q & rdata_shift[31];
        load_ext       = {DATA_WIDTH{load_sign}};
        load_ext[31:0] = rdata_shift[31:0];
      end
    endcase
  end

  // Next-state: request capture, AXI handshakes, ID filtering and response hold
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    uns_d     = uns_q;
    off_d     = off_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    id_d      = id_q;
    id_cnt_d  = id_cnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d    = req_addr;
          size_d    = req_size;
          uns_d     = req_unsigned;
          off_d     = req_off;
          wdata_d   = req_wdata_rep;
          wstrb_d   = req_strb_base << req_off;
          id_d      = id_cnt_q;
          id_cnt_d  = id_cnt_q + 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata_d   = '0;
          err_d     = 2'b00;
          if (req_misaligned) begin
            err_d   = 2'b10;
            state_d = StResp;
          end else begin
            state_d = req_wen ? StAwW : StAr;
          end
        end
      end
      StAr: begin
        if (arready) state_d = StR;
      end
      StR: begin
        // Beats carrying another ID are accepted and dropped
        if (rvalid && (rid == id_q)) begin
          rdata_d = load_ext;
          err_d   = {1'b0, rresp != 2'b00};
          state_d = StResp;
        end
      end
      StAwW: begin
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) state_d = StB;
      end
      StB: begin
        if (bvalid && (bid == id_q)) begin
          err_d   = {1'b0, bresp != 2'b00};
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      off_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      id_q      <= '0;
      id_cnt_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      id_q      <= id_d;
      id_cnt_q  <= id_cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign awvalid = (state_q == StAwW) && !aw_done_q;
  assign awaddr  = addr_q;
  assign awid    = id_q;
  assign awsize  = {1'b0, size_q};
  assign awlen   = 8'd0;
  assign awburst = 2'b01;

  assign wvalid  = (state_q == StAwW) && !w_done_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = wvalid;

  assign bready  = (state_q == StB);

  assign arvalid = (state_q == StAr);
  assign araddr  = addr_q;
  assign arid    = id_q;
  assign arsize  = {1'b0, size_q};
  assign arlen   = 8'd0;
  assign arburst = 2'b01;

  assign rready  = (state_q == StR);

  // Single-beat reads make rlast redundant; upper shifted lanes are never returned
  logic unused_bits;
  assign unused_bits = ^{rlast, rdata_shift[BUS_WIDTH-1:32]};

endmodule

// File: tb/tb_ysyx_23060208_lsu.sv
// Directed plus randomized bench for the load/store unit with a procedural AXI slave
// and a byte-level reference model of alignment, lanes and extension.
module tb_ysyx_23060208_lsu;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 64;
  localparam int unsigned IW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 0, req_ready, req_wen = 0, req_unsigned = 0;
  logic [DW-1:0] req_addr = '0, req_wdata = '0;
  logic [1:0] req_size = '0;
  logic resp_valid, resp_ready = 0;
  logic [DW-1:0] resp_rdata;
  logic [1:0] resp_err;
  logic awvalid, awready = 0, wvalid, wready = 0, wlast, bvalid = 0, bready;
  logic [DW-1:0] awaddr, araddr;
  logic [IW-1:0] awid, arid, bid = '0, rid = '0;
  logic [2:0] awsize, arsize;
  logic [7:0] awlen, arlen;
  logic [1:0] awburst, arburst, bresp = '0, rresp = '0;
  logic [BW-1:0] wdata, rdata = '0;
  logic [BW/8-1:0] wstrb;
  logic arvalid, arready = 0, rvalid = 0, rready, rlast = 1;

  ysyx_23060208_lsu dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awsize(awsize),
    .awlen(awlen), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arsize(arsize),
    .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [IW-1:0] exp_id = '0;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: accesses are n = 2^size bytes, placed at the n-aligned lane slot
  function automatic int unsigned nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic int unsigned lane(input logic [31:0] a, input logic [1:0] sz);
    int unsigned n;
    n = nbytes(sz);
    return ((a % (BW / 8)) / n) * n;
  endfunction

  function automatic logic [31:0] ld_model(input logic [31:0] a, input logic [1:0] sz,
                                           input bit uns, input logic [63:0] bus);
    longint unsigned v;
    int unsigned n, off;
    n = nbytes(sz);
    off = lane(a, sz);
    v = 0;
    for (int j = 0; j < int'(n); j++) v += 64'(bus[8*(off+j) +: 8]) << (8*j);
    if (!uns && v >= (64'd1 << (8*n-1))) v = v + (64'd1 << 32) - (64'd1 << (8*n));
    return v[31:0];
  endfunction

  // One complete request: present, drive the bus side, then take the response
  task automatic run_req(input string tag, input bit wen, input logic [31:0] a,
                         input logic [1:0] sz, input bit uns, input logic [31:0] wd,
                         input logic [63:0] bus, input logic [1:0] xresp, input int d1,
                         input int d2, input int d3, input bit stale, input bit hold);
    int unsigned t0, n, off, exp_lat;
    int k, aw_left, w_left;
    bit mis, aw_done, w_done;
    logic [IW-1:0] id;
    logic [63:0] exp_wd, mask;
    logic [7:0] exp_strb;
    logic [31:0] exp_rd;
    logic [1:0] exp_err;

    mis = is_mis(a, sz);
    id = exp_id;
    exp_id = exp_id + 1'b1;
    exp_rd = (wen || mis) ? 32'd0 : ld_model(a, sz, uns, bus);
    exp_err = mis ? 2'b10 : {1'b0, xresp != 2'b00};
    if (mis) exp_lat = 1;
    else if (wen) exp_lat = 3 + ((d1 > d2) ? d1 : d2) + d3 + stale;
    else exp_lat = 3 + d1 + d3 + stale;

    chk({tag, "_req_ready"}, req_ready, 1);
    req_valid = 1; req_wen = wen; req_addr = a; req_size = sz;
    req_unsigned = uns; req_wdata = wd;
    @(posedge clock);
    @(negedge clock);
    t0 = cyc;
    req_valid = 0;
    req_wdata = $urandom;

    if (!mis && !wen) begin
      k = 0;
      while (!arvalid && k < 20) begin @(negedge clock); k++; end
      chk({tag, "_arvalid"}, arvalid, 1);
      chk({tag, "_araddr"}, araddr, a);
      chk({tag, "_arsize"}, arsize, {1'b0, sz});
      chk({tag, "_arid"}, arid, id);
      repeat (d1) begin
        @(negedge clock);
        chk({tag, "_arvalid_held"}, {arvalid, araddr}, {1'b1, a});
      end
      arready = 1;
      @(negedge clock);
      arready = 0;
      chk({tag, "_rready"}, {arvalid, rready}, 2'b01);
      repeat (d3) @(negedge clock);
      if (stale) begin
        rvalid = 1; rid = id + 4'd1; rdata = {$urandom, $urandom}; rresp = 2'b10;
        @(negedge clock);
        chk({tag, "_stale_r_kept"}, {rready, resp_valid}, 2'b10);
      end
      rvalid = 1; rid = id; rdata = bus; rresp = xresp;
      @(negedge clock);
      rvalid = 0; rdata = {$urandom, $urandom};
    end else if (!mis) begin
      n = nbytes(sz);
      off = lane(a, sz);
      exp_strb = '0; exp_wd = '0; mask = '0;
      for (int i = 0; i < int'(n); i++) begin
        exp_strb[off+i] = 1'b1;
        exp_wd[8*(off+i) +: 8] = wd[8*i +: 8];
        mask[8*(off+i) +: 8] = 8'hff;
      end
      k = 0;
      while (!(awvalid || wvalid) && k < 20) begin @(negedge clock); k++; end
      chk({tag, "_awaddr"}, awaddr, a);
      chk({tag, "_awsize"}, awsize, {1'b0, sz});
      chk({tag, "_awid"}, awid, id);
      chk({tag, "_wstrb"}, wstrb, exp_strb);
      chk({tag, "_wdata_lanes"}, wdata & mask, exp_wd);
      aw_left = d1; w_left = d2; aw_done = 0; w_done = 0; k = 0;
      while (!(aw_done && w_done) && k < 30) begin
        chk({tag, "_aw_w_valids"}, {awvalid, wvalid, wlast, bready},
            {!aw_done, !w_done, !w_done, 1'b0});
        awready = !aw_done && (aw_left == 0);
        wready = !w_done && (w_left == 0);
        if (aw_left > 0) aw_left--;
        if (w_left > 0) w_left--;
        @(negedge clock);
        if (awready) aw_done = 1;
        if (wready) w_done = 1;
        awready = 0; wready = 0;
        k++;
      end
      chk({tag, "_bready"}, {awvalid, wvalid, bready}, 3'b001);
      repeat (d3) @(negedge clock);
      if (stale) begin
        bvalid = 1; bid = id + 4'd1; bresp = 2'b10;
        @(negedge clock);
        chk({tag, "_stale_b_kept"}, {bready, resp_valid}, 2'b10);
      end
      bvalid = 1; bid = id; bresp = xresp;
      @(negedge clock);
      bvalid = 0;
    end

    k = 0;
    while (!resp_valid && k < 40) begin @(negedge clock); k++; end
    chk({tag, "_resp_valid"}, resp_valid, 1);
    chk({tag, "_latency"}, cyc - t0 + 1, exp_lat);
    chk({tag, "_resp_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_resp_err"}, resp_err, exp_err);
    if (mis) chk({tag, "_no_bus"}, {arvalid, awvalid, wvalid}, 3'b000);
    if (hold) begin
      @(negedge clock);
      chk({tag, "_resp_hold"}, {resp_valid, resp_err, resp_rdata}, {1'b1, exp_err, exp_rd});
    end
    resp_ready = 1;
    @(negedge clock);
    resp_ready = 0;
    chk({tag, "_back_idle"}, {req_ready, resp_valid}, 2'b10);
  endtask

  initial begin
    int unsigned n;
    bit wen;
    logic [1:0] sz, xr;
    logic [31:0] a;

    repeat (3) @(negedge clock);
    reset = 0;
    @(negedge clock);
    chk("reset_ready", req_ready, 1);
    chk("reset_valids", {arvalid, awvalid, wvalid, rready, bready, resp_valid}, 6'd0);
    chk("reset_payload", {araddr, awaddr, arid, awid, arsize, awsize}, 64'd0);
    chk("reset_wdata", wdata, 64'd0);
    chk("reset_wstrb_resp", {wstrb, resp_err, resp_rdata}, 64'd0);
    chk("reset_consts", {awlen, arlen, awburst, arburst}, {8'd0, 8'd0, 2'b01, 2'b01});

    run_req("lw_aligned", 0, 32'h8000_0004, 2'd2, 0, 0, 64'h1122_3344_5566_7788, 2'b00,
            0, 0, 0, 0, 0);
    run_req("lb_signed", 0, 32'h8000_0003, 2'd0, 0, 0, 64'h0000_0000_8000_0000, 2'b00,
            0, 0, 0, 0, 1);
    run_req("lbu", 0, 32'h8000_0003, 2'd0, 1, 0, 64'h0000_0000_8000_0000, 2'b00,
            1, 0, 1, 0, 0);
    run_req("sh_aw_delayed", 1, 32'h8000_0006, 2'd1, 0, 32'h0000_abcd, 64'd0, 2'b00,
            3, 0, 0, 0, 0);
    run_req("lw_misaligned", 0, 32'h8000_0002, 2'd2, 0, 0, 64'd0, 2'b00, 0, 0, 0, 0, 1);
    run_req("sw_stale_bid_slverr", 1, 32'h8000_0010, 2'd2, 0, 32'hdead_beef, 64'd0, 2'b11,
            0, 2, 1, 1, 0);
    run_req("lh_rresp_err", 0, 32'h8000_000e, 2'd1, 0, 0, 64'hbeef_1234_0000_0000, 2'b10,
            0, 0, 0, 1, 0);

    // Reset while waiting in R
    chk("rst_mid_ready", req_ready, 1);
    req_valid = 1; req_wen = 0; req_addr = 32'h8000_0020; req_size = 2'd2;
    @(posedge clock);
    @(negedge clock);
    req_valid = 0;
    arready = 1;
    @(negedge clock);
    arready = 0;
    chk("rst_mid_in_r", rready, 1);
    reset = 1;
    @(negedge clock);
    chk("rst_mid_after", {rready, req_ready, arvalid, resp_valid}, 4'b0100);
    reset = 0;
    exp_id = '0;
    run_req("lw_after_reset", 0, 32'h8000_0024, 2'd2, 0, 0, 64'hcafe_f00d_0bad_c0de, 2'b00,
            0, 0, 0, 0, 0);

    // Randomized traffic; the ID counter wraps several times
    for (int t = 0; t < 60; t++) begin
      wen = $urandom_range(0, 1);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = 32'h8000_0000 + $urandom_range(0, 63);
      n = nbytes(sz);
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~(n - 1);
      xr = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_req($sformatf("rand%0d", t), wen, a, sz, 1'($urandom_range(0, 1)), $urandom,
              {$urandom, $urandom}, xr, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
